// File: rtl/sseg_mux_n_if.sv
// Signal bundle between a display client (master) and the seven-segment scanner (slave).
// The client drives the digit/enable inputs; the scanner drives the anode/segment pins and frame pulse.
interface sseg_mux_n_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      en_i;
   logic [4*NUM_DIGITS-1:0]   digits_i;
   logic [NUM_DIGITS-1:0]     dp_i;
   logic [NUM_DIGITS-1:0]     blank_i;
   logic [NUM_DIGITS-1:0]     an_o;
   logic [6:0]                sseg_o;
   logic                      dp_o;
   logic                      frame_o;

   modport master (
      output en_i, digits_i, dp_i, blank_i,
      input  an_o, sseg_o, dp_o, frame_o
   );

   modport slave (
      input  en_i, digits_i, dp_i, blank_i,
      output an_o, sseg_o, dp_o, frame_o
   );
endinterface

// File: rtl/sseg_mux_n.sv
// N-digit seven-segment scanner with hex decode, per-slot anode-off guard and per-frame snapshot.
// Optional: define LEADING_ZERO_BLANK_EN to darken leading zero digits (never digit 0).
module sseg_mux_n #(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   sseg_mux_n_if.slave  bus
);
   localparam int   CW  = $clog2(DWELL_CYCLES);
   localparam int   IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic POL = (ACTIVE_LOW != 0);

   logic [CW-1:0]             r_cnt;
   logic [IW-1:0]             r_idx;
   logic [4*NUM_DIGITS-1:0]   r_snap_dig;
   logic [NUM_DIGITS-1:0]     r_snap_dp;
   logic [NUM_DIGITS-1:0]     r_snap_blank;
   logic [NUM_DIGITS-1:0]     r_an;
   logic [6:0]                r_sseg;
   logic                      r_dp;
   logic                      r_frame;

   logic                      w_last_cnt;
   logic                      w_last_idx;
   logic                      w_frame_start;
   logic                      w_lit;
   logic [3:0]                w_dig;
   logic [NUM_DIGITS-1:0]     w_lz_blank;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      case (h)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   assign w_last_cnt    = (r_cnt == CW'(DWELL_CYCLES - 1));
   assign w_last_idx    = (r_idx == IW'(NUM_DIGITS - 1));
   assign w_frame_start = (r_cnt == '0) && (r_idx == '0);
   assign w_dig         = r_snap_dig[{r_idx, 2'b00} +: 4];
   assign w_lit         = bus.en_i && (r_cnt >= CW'(BLANK_CYCLES)) && !r_snap_blank[r_idx];

`ifdef LEADING_ZERO_BLANK_EN
   logic w_zero_run;
   // Walk down from the most significant digit while digits stay zero; digit 0 always shows.
   always_comb begin
      w_lz_blank = '0;
      w_zero_run = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         if (w_zero_run && (bus.digits_i[4*k +: 4] == 4'h0)) begin
            w_lz_blank[k] = 1'b1;
         end else begin
            w_zero_run = 1'b0;
         end
      end
   end
`else
   assign w_lz_blank = '0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt        <= '0;
         r_idx        <= '0;
         r_snap_dig   <= '0;
         r_snap_dp    <= '0;
         r_snap_blank <= '0;
         r_an         <= {NUM_DIGITS{POL}};
         r_sseg       <= {7{POL}};
         r_dp         <= POL;
         r_frame      <= 1'b0;
      end else begin
         if (!bus.en_i) begin
            r_cnt <= '0;
            r_idx <= '0;
         end else if (w_last_cnt) begin
            r_cnt <= '0;
            r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         // Frame start lies inside the guard interval, so the swap is never visible mid-digit.
         if (bus.en_i && w_frame_start) begin
            r_snap_dig   <= bus.digits_i;
            r_snap_dp    <= bus.dp_i;
            r_snap_blank <= bus.blank_i | w_lz_blank;
         end
         r_frame <= bus.en_i && w_frame_start;
         r_an    <= (w_lit ? (NUM_DIGITS'(1) << r_idx) : '0) ^ {NUM_DIGITS{POL}};
         r_sseg  <= (w_lit ? hex7(w_dig) : 7'h00) ^ {7{POL}};
         r_dp    <= (w_lit & r_snap_dp[r_idx]) ^ POL;
      end
   end

   assign bus.an_o    = r_an;
   assign bus.sseg_o  = r_sseg;
   assign bus.dp_o    = r_dp;
   assign bus.frame_o = r_frame;
endmodule

// File: tb/tb_sseg_mux_n.sv
// Directed bench for sseg_mux_n: 4 digits, 8-cycle slots, 2 guard cycles, active-low outputs.
module tb_sseg_mux_n;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int BW = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   sseg_mux_n_if #(.NUM_DIGITS(N)) bus ();

   sseg_mux_n #(
      .NUM_DIGITS  (N),
      .DWELL_CYCLES(DW),
      .BLANK_CYCLES(BW),
      .ACTIVE_LOW  (1)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Starts at the sample right after the frame-start edge; checks all 32 cycles of one frame.
   task automatic run_frame(input string name,
                            input logic [3:0][3:0] ean, input logic [3:0][6:0] eseg,
                            input logic [3:0] edp, input int chg_at,
                            input logic [15:0] nd, input logic [3:0] ndp, input logic [3:0] nbl);
      int d;
      int j;
      for (int c = 0; c < N*DW; c++) begin
         d = c / DW;
         j = c % DW;
         chk($sformatf("%s frame c%0d", name, c), {31'd0, bus.frame_o}, (c == 0) ? 32'd1 : 32'd0);
         chk($sformatf("%s an c%0d", name, c), {28'd0, bus.an_o}, (j >= BW) ? {28'd0, ean[d]} : 32'hF);
         chk($sformatf("%s sseg c%0d", name, c), {25'd0, bus.sseg_o}, (j >= BW) ? {25'd0, eseg[d]} : 32'h7F);
         chk($sformatf("%s dp c%0d", name, c), {31'd0, bus.dp_o}, (j >= BW) ? {31'd0, edp[d]} : 32'd1);
         if (c == chg_at) begin
            bus.digits_i = nd;
            bus.dp_i     = ndp;
            bus.blank_i  = nbl;
         end
         tick();
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.en_i     = 1'b1;
      bus.digits_i = 16'h1234;
      bus.dp_i     = 4'b0000;
      bus.blank_i  = 4'b0000;
      repeat (3) tick();
      chk("rst an", {28'd0, bus.an_o}, 32'hF);
      chk("rst sseg", {25'd0, bus.sseg_o}, 32'h7F);
      chk("rst dp", {31'd0, bus.dp_o}, 32'd1);
      chk("rst frame", {31'd0, bus.frame_o}, 32'd0);

      // Release, let digit 0 light, then reset mid-slot without a clock edge.
      rst = 1'b0;
      tick();
      chk("rel frame", {31'd0, bus.frame_o}, 32'd1);
      repeat (4) tick();
      chk("pre-rst an", {28'd0, bus.an_o}, 32'hE);
      #2 rst = 1'b1;
      #1;
      chk("async an", {28'd0, bus.an_o}, 32'hF);
      chk("async sseg", {25'd0, bus.sseg_o}, 32'h7F);
      chk("async dp", {31'd0, bus.dp_o}, 32'd1);
      chk("async frame", {31'd0, bus.frame_o}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // 1234; switch to 5678 during the digit-2 slot, invisible until next frame.
      run_frame("f1234", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 18, 16'h5678, 4'b0000, 4'b0000);
      // 5678; blank digit 2 and set dp on digit 0 mid-frame.
      run_frame("f5678", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111, 5, 16'h5678, 4'b0001, 4'b0100);
      // Digit 2 dark, digit 0 with dp; then load 0070 with dp on digit 3.
      run_frame("fblank", {4'b0111, 4'b1111, 4'b1101, 4'b1110},
                {7'h12, 7'h7F, 7'h78, 7'h00}, 4'b1110, 20, 16'h0070, 4'b1000, 4'b0000);
`ifdef LEADING_ZERO_BLANK_EN
      run_frame("f0070", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1111, -1, 16'h0070, 4'b1000, 4'b0000);
`else
      run_frame("f0070", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'h40, 7'h40, 7'h78, 7'h40}, 4'b0111, -1, 16'h0070, 4'b1000, 4'b0000);
`endif

      // Disable for 3 edges in the middle of the digit-1 slot.
      repeat (12) tick();
      chk("pre-dis an", {28'd0, bus.an_o}, 32'hD);
      bus.en_i = 1'b0;
      tick();
      chk("dis an", {28'd0, bus.an_o}, 32'hF);
      chk("dis sseg", {25'd0, bus.sseg_o}, 32'h7F);
      chk("dis dp", {31'd0, bus.dp_o}, 32'd1);
      chk("dis frame", {31'd0, bus.frame_o}, 32'd0);
      tick();
      tick();
      chk("dis3 an", {28'd0, bus.an_o}, 32'hF);
      chk("dis3 frame", {31'd0, bus.frame_o}, 32'd0);
      bus.en_i = 1'b1;
      tick();
`ifdef LEADING_ZERO_BLANK_EN
      run_frame("fren", {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b1111, -1, 16'h0070, 4'b1000, 4'b0000);
`else
      run_frame("fren", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'h40, 7'h40, 7'h78, 7'h40}, 4'b0111, -1, 16'h0070, 4'b1000, 4'b0000);
`endif
      chk("next frame", {31'd0, bus.frame_o}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
